// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the non-restoring divider.
// Imported by the divider top level.
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_RESTORE
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/non_restoring_divider.sv
// Signed multi-cycle non-restoring divider, one quotient bit per cycle.
// Magnitudes are divided unsigned; signs are applied in the final step.
module non_restoring_divider
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic                  valid_entry_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  data_valid_o,
    output logic                  busy_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(DATA_WIDTH);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [W:0]      rem_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    dvs_q;
    logic            q_neg_q;
    logic            r_neg_q;

    logic            dvs_zero;
    logic            last_step;
    logic [W-1:0]    dvd_abs;
    logic [W-1:0]    dvs_abs;
    logic [W:0]      shifted;
    logic [W:0]      stepped;
    logic [W-1:0]    rem_fix;
    logic [W-1:0]    quo_sgn;
    logic [W-1:0]    rem_sgn;

    assign dvs_zero  = (divisor_i == '0);
    assign last_step = (cnt_q == CW'(W - 1));

    assign dvd_abs = dividend_i[W-1] ? (~dividend_i + W'(1)) : dividend_i;
    assign dvs_abs = divisor_i[W-1]  ? (~divisor_i + W'(1))  : divisor_i;

    // A negative partial remainder is carried forward and repaired by
    // adding on the next step instead of restoring immediately.
    assign shifted = {rem_q[W-1:0], quo_q[W-1]};
    assign stepped = rem_q[W] ? (shifted + {1'b0, dvs_q})
                              : (shifted - {1'b0, dvs_q});

    assign rem_fix = rem_q[W-1:0] + (rem_q[W] ? dvs_q : '0);
    assign quo_sgn = q_neg_q ? (~quo_q + W'(1))   : quo_q;
    assign rem_sgn = r_neg_q ? (~rem_fix + W'(1)) : rem_fix;

    assign busy_o = (state_q != ST_IDLE);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; nothing moves while the clock enable is low
    always_comb begin
        state_d = state_q;
        if (clk_en_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (valid_entry_i && !dvs_zero) begin
                        state_d = ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (last_step) begin
                        state_d = ST_RESTORE;
                    end
                end
                ST_RESTORE: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath, step counter and registered results
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q            <= '0;
            rem_q            <= '0;
            quo_q            <= '0;
            dvs_q            <= '0;
            q_neg_q          <= 1'b0;
            r_neg_q          <= 1'b0;
            quotient_o       <= '0;
            remainder_o      <= '0;
            divide_by_zero_o <= 1'b0;
            data_valid_o     <= 1'b0;
        end else if (clk_en_i) begin
            data_valid_o <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (valid_entry_i && dvs_zero) begin
                        quotient_o       <= '1;
                        remainder_o      <= dividend_i;
                        divide_by_zero_o <= 1'b1;
                        data_valid_o     <= 1'b1;
                    end else if (valid_entry_i) begin
                        rem_q   <= '0;
                        quo_q   <= dvd_abs;
                        dvs_q   <= dvs_abs;
                        q_neg_q <= dividend_i[W-1] ^ divisor_i[W-1];
                        r_neg_q <= dividend_i[W-1];
                        cnt_q   <= '0;
                    end
                end
                ST_DIVIDE: begin
                    rem_q <= stepped;
                    quo_q <= {quo_q[W-2:0], ~stepped[W]};
                    cnt_q <= cnt_q + CW'(1);
                end
                ST_RESTORE: begin
                    quotient_o       <= quo_sgn;
                    remainder_o      <= rem_sgn;
                    divide_by_zero_o <= 1'b0;
                    data_valid_o     <= 1'b1;
                    cnt_q            <= '0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_non_restoring_divider.sv
// Directed scoreboard bench for the non-restoring divider.
// Results are predicted from native signed division.
module tb_non_restoring_divider;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        valid_entry;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dbz;
    logic        data_valid;
    logic        busy;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    non_restoring_divider #(.DATA_WIDTH(32)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .clk_en_i         (clk_en),
        .valid_entry_i    (valid_entry),
        .dividend_i       (dividend),
        .divisor_i        (divisor),
        .quotient_o       (quotient),
        .remainder_o      (remainder),
        .divide_by_zero_o (dbz),
        .data_valid_o     (data_valid),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic signed [31:0] a,
                                   input logic signed [31:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
            e.q = 32'h8000_0000;
            e.r = 32'h0;
            e.z = 1'b0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"}, quotient, e.q);
            check({tag, "_r"}, remainder, e.r);
            check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, e.z});
        end
    endtask

    // Starts and ends just after a falling edge.
    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input int exp_busy, input int frz_at,
                          input int frz_len);
        int n;
        int bc;
        sb.push_back(model(a, b));
        dividend    = a;
        divisor     = b;
        valid_entry = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_entry = 1'b0;
        n  = 1;
        bc = 0;
        while (!data_valid && n < 200) begin
            if (busy) bc++;
            if (n == frz_at) clk_en = 1'b0;
            if (n == frz_at + frz_len) clk_en = 1'b1;
            @(negedge clk);
            n++;
        end
        clk_en = 1'b1;
        check({tag, "_lat"}, n, exp_lat);
        if (exp_busy >= 0) check({tag, "_busy"}, bc, exp_busy);
        pop_check(tag);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, data_valid}, 32'd0);
    endtask

    initial begin : stim
        int n;
        rst_n       = 1'b0;
        clk_en      = 1'b1;
        valid_entry = 1'b0;
        dividend    = '0;
        divisor     = '0;
        #1;
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_flags", {29'd0, dbz, data_valid, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("p_p", 32'd100, 32'd7, 34, 33, 0, 0);
        run_op("n_p", -32'sd100, 32'd7, 34, 33, 0, 0);
        run_op("p_n", 32'd100, -32'sd7, 34, 33, 0, 0);
        run_op("n_n", -32'sd100, -32'sd7, 34, 33, 0, 0);
        run_op("dbz", 32'd5, 32'd0, 1, 0, 0, 0);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 34, 33, 0, 0);
        run_op("min1", 32'h8000_0000, 32'd1, 34, 33, 0, 0);
        run_op("clr_dbz", 32'd7, 32'd7, 34, 33, 0, 0);
        run_op("big", 32'h7FFF_FFFF, 32'h8000_0000, 34, 33, 0, 0);
        run_op("frz", 32'd12345, -32'sd17, 44, 43, 5, 10);

        // Abort an operation with reset mid-divide
        dividend    = 32'd1000;
        divisor     = 32'd3;
        valid_entry = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_entry = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", quotient, 32'd0);
        check("mid_rst_r", remainder, 32'd0);
        check("mid_rst_flags", {29'd0, dbz, data_valid, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 32'd9, 32'd3, 34, 33, 0, 0);

        // Back-to-back with valid held high through the divide
        sb.push_back(model(32'd1000, 32'd10));
        dividend    = 32'd1000;
        divisor     = 32'd10;
        valid_entry = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.push_back(model(32'd7, -32'sd2));
        dividend = 32'd7;
        divisor  = -32'sd2;
        n = 1;
        while (!data_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b1_lat", n, 34);
        pop_check("b2b1");
        @(negedge clk);
        valid_entry = 1'b0;
        check("b2b_hold_q", quotient, 32'd100);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        n = 1;
        while (!data_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b2_lat", n, 34);
        pop_check("b2b2");
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
